nmea_feed_ctrl: RTL and testbench

//  Sequencer between UART RX byte stream and nmea_parser. Buffers RX bytes in a small FIFO.

---
 rtl/nmea_feed_ctrl_if.sv | 19 +
 rtl/nmea_feed_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_nmea_feed_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmea_feed_ctrl_if.sv
// Byte-stream bundle between the UART receiver, nmea_feed_ctrl and the nmea_parser.
// rx_valid and p_valid are single-cycle strobes qualifying rx_data / p_char; there is no ready, the consumer must take the byte.
interface nmea_feed_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] p_char;
   logic       p_valid;
   logic       p_lat_ready;

   modport master (
      output rx_data, rx_valid, p_lat_ready,
      input  p_char, p_valid
   );

   modport slave (
      input  rx_data, rx_valid, p_lat_ready,
      output p_char, p_valid
   );
endinterface

// File: rtl/nmea_feed_ctrl.sv
// RX byte FIFO feeding nmea_parser, NMEA "*hh" checksum qualification of fixes, fix staleness timer.
// Define NMEA_CKSUM_CHECK_EN to build the checksum FSM; otherwise fix_strobe is p_lat_ready delayed one cycle.
module nmea_feed_ctrl #(
   parameter int FIFO_DEPTH  = 16,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   nmea_feed_ctrl_if.slave bus,
   output logic            fix_strobe,
   output logic            fix_stale,
   output logic [7:0]      cksum_err_cnt,
   output logic            fifo_ovf,
   output logic [1:0]      cksum_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC - 1);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [7:0]    pop_byte;
   logic          strobe_n;
   logic [TW-1:0] to_cnt;

   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign pop      = enable && !empty;
   // A full FIFO still accepts a byte when the same cycle frees a slot.
   assign push     = bus.rx_valid && (!full || pop);
   assign pop_byte = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         fifo_ovf    <= 1'b0;
         bus.p_char  <= 8'd0;
         bus.p_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr     <= rd_ptr + AW'(1);
            bus.p_char <= pop_byte;
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (bus.rx_valid && full && !pop) fifo_ovf <= 1'b1;
         bus.p_valid <= pop;
      end
   end

`ifdef NMEA_CKSUM_CHECK_EN
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SUM  = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_LO   = 2'd3;

   logic [1:0] state, state_n;
   logic [7:0] sum, sum_n;
   logic [3:0] hi_nib, hi_nib_n;
   logic       pending, pending_n;
   logic       err_hit;
   logic       fix_hit;
   logic       is_dollar;
   logic       is_star;
   logic       is_hex;
   logic [3:0] nib;

   always_comb begin
      is_dollar = (pop_byte == 8'h24);
      is_star   = (pop_byte == 8'h2A);
      is_hex    = 1'b0;
      nib       = 4'd0;
      if (pop_byte >= 8'h30 && pop_byte <= 8'h39) begin
         is_hex = 1'b1;
         nib    = pop_byte[3:0];
      end else if (pop_byte >= 8'h41 && pop_byte <= 8'h46) begin
         is_hex = 1'b1;
         nib    = pop_byte[3:0] + 4'd9;
      end
   end

   // The FSM follows exactly the bytes handed to the parser, so it only advances on pop.
   always_comb begin
      state_n   = state;
      sum_n     = sum;
      hi_nib_n  = hi_nib;
      pending_n = pending || (bus.p_lat_ready && state != ST_IDLE);
      err_hit   = 1'b0;
      fix_hit   = 1'b0;
      if (pop) begin
         case (state)
            ST_IDLE: begin
               if (is_dollar) begin
                  state_n   = ST_SUM;
                  sum_n     = 8'd0;
                  pending_n = 1'b0;
               end
            end
            ST_SUM: begin
               if (is_star) begin
                  state_n = ST_HI;
               end else if (is_dollar) begin
                  sum_n     = 8'd0;
                  pending_n = 1'b0;
               end else begin
                  sum_n = sum ^ pop_byte;
               end
            end
            ST_HI: begin
               if (is_hex) begin
                  state_n  = ST_LO;
                  hi_nib_n = nib;
               end else if (is_dollar) begin
                  state_n   = ST_SUM;
                  sum_n     = 8'd0;
                  pending_n = 1'b0;
               end else begin
                  state_n   = ST_IDLE;
                  pending_n = 1'b0;
                  err_hit   = 1'b1;
               end
            end
            default: begin
               if (is_hex) begin
                  state_n   = ST_IDLE;
                  pending_n = 1'b0;
                  if ({hi_nib, nib} == sum) fix_hit = pending;
                  else                      err_hit = 1'b1;
               end else if (is_dollar) begin
                  state_n   = ST_SUM;
                  sum_n     = 8'd0;
                  pending_n = 1'b0;
               end else begin
                  state_n   = ST_IDLE;
                  pending_n = 1'b0;
                  err_hit   = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         sum           <= 8'd0;
         hi_nib        <= 4'd0;
         pending       <= 1'b0;
         cksum_err_cnt <= 8'd0;
      end else begin
         state   <= state_n;
         sum     <= sum_n;
         hi_nib  <= hi_nib_n;
         pending <= pending_n;
         if (err_hit && cksum_err_cnt != 8'hFF) cksum_err_cnt <= cksum_err_cnt + 8'd1;
      end
   end

   assign strobe_n    = fix_hit;
   assign cksum_state = state;
`else
   assign strobe_n      = bus.p_lat_ready;
   assign cksum_err_cnt = 8'd0;
   assign cksum_state   = 2'd0;
`endif

   // The strobe edge also restarts the staleness timer, so fix_stale drops with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         fix_strobe <= 1'b0;
         to_cnt     <= '0;
      end else begin
         fix_strobe <= strobe_n;
         if (strobe_n)            to_cnt <= '0;
         else if (to_cnt != T_MAX) to_cnt <= to_cnt + TW'(1);
      end
   end

   assign fix_stale = (to_cnt == T_MAX);

endmodule

// File: tb/tb_nmea_feed_ctrl.sv
// Scoreboard bench for nmea_feed_ctrl: random NMEA traffic, a mock parser, and a sentence-level reference model.
module tb_nmea_feed_ctrl;
   localparam int FIFO_DEPTH = 16;
   localparam int TIMEOUT    = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       fix_strobe;
   logic       fix_stale;
   logic [7:0] cksum_err_cnt;
   logic       fifo_ovf;
   logic [1:0] cksum_state;

   nmea_feed_ctrl_if bus();

   nmea_feed_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .enable(enable), .bus(bus),
      .fix_strobe(fix_strobe), .fix_stale(fix_stale), .cksum_err_cnt(cksum_err_cnt),
      .fifo_ovf(fifo_ovf), .cksum_state(cksum_state)
   );

   always #5 clk = ~clk;

   logic [7:0]  byte_q[$];
   logic [31:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int pushed_cnt = 0;
   int deliv_cnt = 0;
   int err_m = 0;
   int cyc = 0;
   logic [31:0] tag;
   logic [7:0]  exp_b;

   string rmc = "GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";
   string gga = "GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int hexval(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      return -1;
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
   endfunction

   function automatic logic [7:0] xsum(input string s);
      logic [7:0] x = 8'd0;
      for (int i = 0; i < s.len(); i++) x ^= s[i];
      return x;
   endfunction

   // A fix is reported only for GPRMC sentences long enough for the parser to capture lat/lon.
   function automatic bit is_rmc(input string s);
      int commas = 0;
      if (s.len() < 5 || s.substr(0, 4) != "GPRMC") return 1'b0;
      for (int i = 0; i < s.len(); i++) if (s[i] == ",") commas++;
      return commas >= 7;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic send_byte(input logic [7:0] b, input bit keep);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      if (keep) begin
         byte_q.push_back(b);
         pushed_cnt++;
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_byte(s[i], 1'b1);
      end
   endtask

   task automatic send_sentence(input string body, input logic [7:0] hi_c, input logic [7:0] lo_c);
      logic [7:0] cs;
      int hv, lv;
      bit ok;
      cs = xsum(body);
      send_str({"$", body, "*"});
      send_byte(hi_c, 1'b1);
      send_byte(lo_c, 1'b1);
      hv = hexval(hi_c);
      lv = hexval(lo_c);
      ok = (hv >= 0) && (lv >= 0) && ((hv * 16 + lv) == int'(cs));
`ifdef NMEA_CKSUM_CHECK_EN
      if (ok) begin
         if (is_rmc(body)) exp_q.push_back(pushed_cnt);
      end else if (err_m < 255) begin
         err_m++;
      end
`endif
   endtask

   task automatic send_good(input string body);
      logic [7:0] cs;
      cs = xsum(body);
      send_sentence(body, hex_char(cs[7:4]), hex_char(cs[3:0]));
   endtask

   task automatic send_random_sentence();
      string body = "";
      logic [7:0] cs, hc, lc;
      int len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) body = {body, $sformatf("%c", 8'($urandom_range(8'h30, 8'h5A)))};
      cs = xsum(body);
      hc = hex_char(cs[7:4]);
      lc = hex_char(cs[3:0]);
      case ($urandom_range(0, 3))
         1: begin hc = hex_char(cs[7:4]); lc = hex_char(cs[3:0] ^ 4'h1); end
         2: hc = "G";
         3: begin
            if (hc >= "A") hc = hc + 8'h20;
            if (lc >= "A") lc = lc + 8'h20;
         end
         default: ;
      endcase
      send_sentence(body, hc, lc);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (byte_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", byte_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      byte_q.delete();
      exp_q.delete();
      pushed_cnt = 0;
      deliv_cnt  = 0;
      err_m      = 0;
      check("rst_p_valid", bus.p_valid, 0);
      check("rst_p_char", bus.p_char, 0);
      check("rst_fix_strobe", fix_strobe, 0);
      check("rst_fix_stale", fix_stale, 0);
      check("rst_err_cnt", cksum_err_cnt, 0);
      check("rst_fifo_ovf", fifo_ovf, 0);
      check("rst_state", cksum_state, 0);
      rst = 1'b0;
   endtask

   // Mock parser: pulses p_lat_ready after the lon-hemisphere comma of a GPRMC sentence.
   initial begin
      bit in_sent = 1'b0;
      int commas = 0;
      logic [39:0] hdr = '0;
      bus.p_lat_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.p_lat_ready = 1'b0;
         if (rst) begin
            in_sent = 1'b0;
            commas  = 0;
         end else if (bus.p_valid) begin
            if (bus.p_char == "$") begin
               in_sent = 1'b1;
               commas  = 0;
               hdr     = '0;
            end else if (bus.p_char == "*") begin
               in_sent = 1'b0;
            end else if (in_sent) begin
               if (bus.p_char == ",") begin
                  commas++;
                  if (commas == 7 && hdr == "GPRMC") begin
                     bus.p_lat_ready = 1'b1;
`ifndef NMEA_CKSUM_CHECK_EN
                     exp_q.push_back(cyc + 1);
`endif
                  end
               end else if (commas == 0) begin
                  hdr = {hdr[31:0], bus.p_char};
               end
            end
         end
      end
   end

   // Monitor: every delivered byte and every fix strobe is matched against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (bus.p_valid) begin
            deliv_cnt++;
            if (byte_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL p_unexpected actual=%0h required=none", bus.p_char);
            end else begin
               exp_b = byte_q.pop_front();
               check("p_char", bus.p_char, exp_b);
            end
         end
         if (fix_strobe) begin
`ifdef NMEA_CKSUM_CHECK_EN
            tag = deliv_cnt;
`else
            tag = cyc;
`endif
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL strobe_unexpected actual=%0d required=none", tag);
            end else begin
               check("strobe_pos", tag, exp_q.pop_front());
            end
            check("stale_on_strobe", fix_stale, 0);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] b, last_b;
      int run;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'd0;
      @(negedge clk);
      do_reset();

      for (int k = 1; k <= TIMEOUT - 1; k++) begin
         @(negedge clk);
         if (k == TIMEOUT - 2) check("stale_early", fix_stale, 0);
         if (k == TIMEOUT - 1) check("stale_rise", fix_stale, 1);
      end

      enable = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h51;
      byte_q.push_back(8'h51);
      pushed_cnt++;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check("lat_edge_t", bus.p_valid, 0);
      @(negedge clk);
      check("lat_edge_t1_valid", bus.p_valid, 1);
      check("lat_edge_t1_char", bus.p_char, 8'h51);
      @(negedge clk);
      check("lat_single", bus.p_valid, 0);

      send_good(rmc);
      wait_drain();
      check("good_rmc_err", cksum_err_cnt, err_m);
      check("good_rmc_strobe", exp_q.size(), 0);
      check("good_rmc_stale", fix_stale, 0);

      send_sentence(rmc, hex_char(xsum(rmc)[7:4]), hex_char(xsum(rmc)[3:0] ^ 4'h1));
      wait_drain();
      check("bad_rmc_err", cksum_err_cnt, err_m);

      send_good(gga);
      wait_drain();
      check("gga_err", cksum_err_cnt, err_m);

      repeat (40) send_random_sentence();
      wait_drain();
      check("random_err", cksum_err_cnt, err_m);

      enable = 1'b0;
      last_b = 8'd0;
      for (int i = 0; i <= FIFO_DEPTH; i++) begin
         b = 8'($urandom_range(8'h30, 8'h7A));
         if (i < FIFO_DEPTH) last_b = b;
         send_byte(b, i < FIFO_DEPTH);
      end
      @(negedge clk);
      check("ovf_set", fifo_ovf, 1);
      check("hold_no_valid", bus.p_valid, 0);
      enable = 1'b1;
      run = 0;
      for (int i = 0; i < FIFO_DEPTH + 4; i++) begin
         @(negedge clk);
         if (bus.p_valid) run++;
         else if (run > 0) break;
      end
      check("drain_run", run, FIFO_DEPTH);
      check("p_char_hold", bus.p_char, last_b);
      wait_drain();
      check("ovf_sticky", fifo_ovf, 1);

      send_str("$GPRMC,123519,A,4807.038,N,01131.000,E,");
      send_good(rmc);
      wait_drain();
      check("restart_err", cksum_err_cnt, err_m);
      check("restart_strobe", exp_q.size(), 0);

      send_str("$GPRMC,123519,A,48");
      do_reset();
      enable = 1'b1;
      send_str("01131.000,E,*5A");
      send_good(rmc);
      wait_drain();
      check("post_rst_err", cksum_err_cnt, err_m);
      check("post_rst_strobe", exp_q.size(), 0);

      repeat (260) begin
         if ($urandom_range(0, 7) == 0) send_random_sentence();
         else                           send_sentence("A", "0", "0");
      end
      wait_drain();
      check("sat_err", cksum_err_cnt, err_m);

      check("final_exp_q", exp_q.size(), 0);
      check("final_byte_q", byte_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
